data_mem_responder: RTL

- Memory-side responder for the CPU data-memory port.
- Accepts load/store requests over a valid/ready request channel, inserts a programmable number of wait states, commits stores with byte enables, and returns a response carrying read data and an error flag.
- Sits between the CPU's load/store datapath (address from the ALU result, store data from register read port 2) and the word-organised data storage.
- Lets the CPU be tested against a slow memory.

---
 rtl/data_mem_responder.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// Data-memory responder: valid/ready request channel, programmable wait states,
// byte-enabled stores and a registered response carrying read data and an error flag.
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);
    localparam bit          ZERO_WAIT = (WAIT_CYCLES == 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        req_ready_q, req_ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        wr_q, wr_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic        commit;
    logic        c_write;
    logic [31:0] c_addr;
    logic [31:0] c_wdata;
    logic [3:0]  c_be;
    logic [31:0] word_idx;
    logic        c_err;
    logic [31:0] mem_rd;
    logic        mem_we;

    // With no wait states the commit happens on the accepting edge, so it must
    // see the live request rather than the copy being latched on that same edge.
    always_comb begin
        c_write = ZERO_WAIT ? req_write : wr_q;
        c_addr  = ZERO_WAIT ? req_addr  : addr_q;
        c_wdata = ZERO_WAIT ? req_wdata : wdata_q;
        c_be    = ZERO_WAIT ? req_be    : be_q;
    end

    always_comb begin
        word_idx = (c_addr - BASE_ADDR) >> 2;
        c_err    = (c_addr[1:0] != 2'b00) || (c_addr < BASE_ADDR) ||
                   (word_idx >= 32'(DEPTH_WORDS));
        mem_rd   = mem_q[word_idx[IDX_W-1:0]];
        mem_we   = commit && c_write && !c_err;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        commit  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    wr_d    = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    be_d    = req_be;
                    if (ZERO_WAIT) begin
                        commit  = 1'b1;
                        state_d = RESP;
                    end else begin
                        cnt_d   = WAIT_INIT;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    commit  = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                    rdata_d = '0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (commit) begin
            err_d   = c_err;
            rdata_d = (c_write || c_err) ? 32'h0 : mem_rd;
        end

        // Handshake flags are registered from the next state, so req_ready
        // only reappears the cycle after a response handshake.
        req_ready_d  = (state_d == IDLE);
        resp_valid_d = (state_d == RESP);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            rdata_q      <= 32'h0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        wr_q    <= wr_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        be_q    <= be_d;
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (c_be[i]) begin
                    mem_q[word_idx[IDX_W-1:0]][8*i +: 8] <= c_wdata[8*i +: 8];
                end
            end
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule
